// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   typedef enum logic {
      CORE  = 1'b0,
      DEBUG = 1'b1
   } owner_e;

   localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
   localparam logic [5:0]  LED_RESET = 6'b111111;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core and debug-loader request/response bus into the arbiter
interface dmem_arbiter_if;

   logic        c_req;
   logic        c_we;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic [31:0] c_rdata;
   logic        c_ready;

   logic        d_req;
   logic        d_we;
   logic        d_lock;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      input  c_rdata, c_ready,
      output d_req, d_we, d_lock, d_addr, d_wdata,
      input  d_rdata, d_ready
   );

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      output c_rdata, c_ready,
      input  d_req, d_we, d_lock, d_addr, d_wdata,
      output d_rdata, d_ready
   );

endinterface

// File: rtl/dmem_addr_decode.sv
// rtl/dmem_addr_decode.sv - combinational byte-address decode into RAM, LED register or unmapped
module dmem_addr_decode
   import dmem_arbiter_pkg::*;
#(
   parameter logic [31:0] LED_ADDR  = 32'h0000_0020,
   parameter int unsigned RAM_WORDS = 16
) (
   input  logic [31:0] addr_i,
   output logic        is_ram_o,
   output logic        is_led_o,
   output logic        is_unmapped_o
);

   localparam logic [29:0] LED_WORD  = LED_ADDR[31:2];
   localparam logic [29:0] RAM_LIMIT = 30'(RAM_WORDS);

   // The LED word may alias into the RAM window, so it takes priority.
   assign is_led_o      = (addr_i[31:2] == LED_WORD);
   assign is_ram_o      = !is_led_o && (addr_i[31:2] < RAM_LIMIT);
   assign is_unmapped_o = !is_led_o && !is_ram_o;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin core/debug arbiter over a shared data RAM and LED register
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter logic [31:0] LED_ADDR  = 32'h0000_0020,
   parameter int unsigned RAM_WORDS = 16
) (
   input  logic                         clk,
   input  logic                         sys_rst_n,
   dmem_arbiter_if.slave                bus,
   output logic [$clog2(RAM_WORDS)-1:0] ram_ad_o,
   output logic [31:0]                  ram_di_o,
   output logic                         ram_wre_o,
   input  logic [31:0]                  ram_dout_i,
   output logic [5:0]                   led_o,
   output logic                         err_o
);

   localparam int AW = $clog2(RAM_WORDS);

   state_e      state_q, state_d;
   owner_e      owner_q, owner_d;
   owner_e      last_q, last_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [5:0]  led_q, led_d;
   logic        c_ready_q, c_ready_d;
   logic        d_ready_q, d_ready_d;
   logic        err_q, err_d;
   logic [31:0] c_rdata_q, c_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic        is_ram, is_led, is_unmapped;
   logic        core_ok;
   logic        take;
   owner_e      gnt;
   logic [31:0] rd_data;

   dmem_addr_decode #(
      .LED_ADDR  (LED_ADDR),
      .RAM_WORDS (RAM_WORDS)
   ) u_decode (
      .addr_i        (addr_q),
      .is_ram_o      (is_ram),
      .is_led_o      (is_led),
      .is_unmapped_o (is_unmapped)
   );

   // A locked debug owner shuts the core out until the lock is released.
   assign core_ok = bus.c_req && !(bus.d_lock && (last_q == DEBUG));

   assign rd_data = is_led ? {26'b0, ~led_q} :
                    is_ram ? ram_dout_i      : ERR_DATA;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      led_d     = led_q;
      c_ready_d = 1'b0;
      d_ready_d = 1'b0;
      err_d     = 1'b0;
      c_rdata_d = c_rdata_q;
      d_rdata_d = d_rdata_q;
      take      = 1'b0;
      gnt       = CORE;

      case (state_q)
         IDLE: begin
            if (bus.d_req && core_ok) begin
               take = 1'b1;
               gnt  = (last_q == CORE) ? DEBUG : CORE;
            end else if (bus.d_req) begin
               take = 1'b1;
               gnt  = DEBUG;
            end else if (core_ok) begin
               take = 1'b1;
               gnt  = CORE;
            end
            if (take) begin
               state_d = ISSUE;
               owner_d = gnt;
               last_d  = gnt;
               we_d    = (gnt == DEBUG) ? bus.d_we    : bus.c_we;
               addr_d  = (gnt == DEBUG) ? bus.d_addr  : bus.c_addr;
               wdata_d = (gnt == DEBUG) ? bus.d_wdata : bus.c_wdata;
            end
         end
         ISSUE: begin
            state_d = RESP;
            if (we_q && is_led) begin
               led_d = ~wdata_q[5:0];
            end
         end
         RESP: begin
            state_d = IDLE;
            err_d   = is_unmapped;
            if (owner_q == DEBUG) begin
               d_ready_d = 1'b1;
               d_rdata_d = rd_data;
            end else begin
               c_ready_d = 1'b1;
               c_rdata_d = rd_data;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         owner_q   <= CORE;
         last_q    <= CORE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         led_q     <= LED_RESET;
         c_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         err_q     <= 1'b0;
         c_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         led_q     <= led_d;
         c_ready_q <= c_ready_d;
         d_ready_q <= d_ready_d;
         err_q     <= err_d;
         c_rdata_q <= c_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign ram_ad_o    = addr_q[AW+1:2];
   assign ram_di_o    = wdata_q;
   assign ram_wre_o   = (state_q == ISSUE) && we_q && is_ram;
   assign led_o       = led_q;
   assign err_o       = err_q;
   assign bus.c_ready = c_ready_q;
   assign bus.d_ready = d_ready_q;
   assign bus.c_rdata = c_rdata_q;
   assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clk;
   logic        sys_rst_n;
   logic [3:0]  ram_ad;
   logic [31:0] ram_di;
   logic        ram_wre;
   logic [31:0] ram_dout;
   logic [5:0]  led;
   logic        err;

   int tests = 0;
   int fails = 0;

   int          wre_cnt = 0;
   int          c_cnt = 0;
   int          d_cnt = 0;
   int          both_cnt = 0;
   logic [3:0]  last_wre_ad = '0;
   logic [31:0] last_wre_di = '0;

   logic [31:0] mem [16];

   dmem_arbiter_if bus();

   dmem_arbiter dut (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .bus        (bus.slave),
      .ram_ad_o   (ram_ad),
      .ram_di_o   (ram_di),
      .ram_wre_o  (ram_wre),
      .ram_dout_i (ram_dout),
      .led_o      (led),
      .err_o      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wre) mem[ram_ad] <= ram_di;
      ram_dout <= mem[ram_ad];
   end

   always @(negedge clk) begin
      if (ram_wre) begin
         wre_cnt++;
         last_wre_ad = ram_ad;
         last_wre_di = ram_di;
      end
      if (bus.c_ready) c_cnt++;
      if (bus.d_ready) d_cnt++;
      if (bus.c_ready && bus.d_ready) both_cnt++;
   end

   task automatic core_acc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat, output logic er);
      bit done = 0;
      bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = a; bus.c_wdata = wd;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         lat++;
         if (bus.c_ready) begin done = 1; break; end
      end
      rd = bus.c_rdata;
      er = err;
      if (!done) lat = 99;
      bus.c_req = 1'b0;
   endtask

   task automatic dbg_acc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output logic er);
      bit done = 0;
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_lock = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         lat++;
         if (bus.d_ready) begin done = 1; break; end
      end
      rd = bus.d_rdata;
      er = err;
      if (!done) lat = 99;
      bus.d_req = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      tests++; if (bus.c_ready !== 1'b0) begin fails++; $display("FAIL reset_c_ready got %b want 0", bus.c_ready); end
      tests++; if (bus.d_ready !== 1'b0) begin fails++; $display("FAIL reset_d_ready got %b want 0", bus.d_ready); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
      tests++; if (ram_wre !== 1'b0) begin fails++; $display("FAIL reset_ram_wre got %b want 0", ram_wre); end
      tests++; if (bus.c_rdata !== 32'h0) begin fails++; $display("FAIL reset_c_rdata got %h want 0", bus.c_rdata); end
      tests++; if (bus.d_rdata !== 32'h0) begin fails++; $display("FAIL reset_d_rdata got %h want 0", bus.d_rdata); end
      tests++; if (led !== 6'b111111) begin fails++; $display("FAIL reset_led got %b want 111111", led); end
      sys_rst_n = 1'b1;
   endtask

   task automatic test_ram_rw();
      logic [31:0] rd;
      int          lat;
      logic        er;
      int          w0;
      w0 = wre_cnt;
      core_acc(1'b1, 32'h04, 32'h1234_5678, rd, lat, er);
      tests++; if (lat !== 3) begin fails++; $display("FAIL ram_wr_latency got %0d want 3", lat); end
      tests++; if (wre_cnt - w0 !== 1) begin fails++; $display("FAIL ram_wr_pulses got %0d want 1", wre_cnt - w0); end
      tests++; if (last_wre_ad !== 4'd1) begin fails++; $display("FAIL ram_wr_ad got %0d want 1", last_wre_ad); end
      tests++; if (last_wre_di !== 32'h1234_5678) begin fails++; $display("FAIL ram_wr_di got %h want 12345678", last_wre_di); end
      core_acc(1'b0, 32'h04, 32'h0, rd, lat, er);
      tests++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL ram_rd_data got %h want 12345678", rd); end
      tests++; if (lat !== 3) begin fails++; $display("FAIL ram_rd_latency got %0d want 3", lat); end
      tests++; if (er !== 1'b0) begin fails++; $display("FAIL ram_rd_err got %b want 0", er); end
      core_acc(1'b1, 32'h3C, 32'hCAFE_0001, rd, lat, er);
      tests++; if (last_wre_ad !== 4'd15) begin fails++; $display("FAIL ram_top_ad got %0d want 15", last_wre_ad); end
      core_acc(1'b0, 32'h3F, 32'h0, rd, lat, er);
      tests++; if (rd !== 32'hCAFE_0001) begin fails++; $display("FAIL ram_byte_ignored got %h want cafe0001", rd); end
   endtask

   task automatic test_contention();
      logic [3:0] seq = '0;
      int         idx = 0;
      int         cyc = 0;
      int         last_cyc = 0;
      int         b0;
      logic [31:0] c_rd = '0;
      logic [31:0] d_rd = '0;
      sys_rst_n = 1'b0;
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h04; bus.c_wdata = 32'h0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3C; bus.d_wdata = 32'h0; bus.d_lock = 1'b0;
      @(negedge clk); #1;
      b0 = both_cnt;
      sys_rst_n = 1'b1;
      while (idx < 4 && cyc < 30) begin
         @(negedge clk); #1;
         cyc++;
         if (bus.d_ready || bus.c_ready) begin
            seq[idx] = bus.d_ready;
            if (bus.d_ready) d_rd = bus.d_rdata;
            if (bus.c_ready) c_rd = bus.c_rdata;
            idx++;
            last_cyc = cyc;
         end
      end
      bus.c_req = 1'b0;
      bus.d_req = 1'b0;
      tests++; if (idx !== 4) begin fails++; $display("FAIL rr_count got %0d want 4", idx); end
      tests++; if (seq !== 4'b0101) begin fails++; $display("FAIL rr_order got %b want 0101 (bit0 first, 1=debug)", seq); end
      tests++; if (last_cyc !== 12) begin fails++; $display("FAIL rr_throughput got %0d want 12", last_cyc); end
      tests++; if (both_cnt - b0 !== 0) begin fails++; $display("FAIL rr_both_ready got %0d want 0", both_cnt - b0); end
      tests++; if (d_rd !== 32'hCAFE_0001) begin fails++; $display("FAIL rr_d_rdata got %h want cafe0001", d_rd); end
      tests++; if (c_rd !== 32'h1234_5678) begin fails++; $display("FAIL rr_c_rdata got %h want 12345678", c_rd); end
   endtask

   task automatic test_lock();
      int c0, dd0, w0;
      int n = 0;
      bit got;
      c0 = c_cnt; dd0 = d_cnt; w0 = wre_cnt;
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h0C; bus.c_wdata = 32'h0;
      bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'h1111_1111;
      for (int k = 0; k < 3; k++) begin
         got = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (bus.d_ready) begin got = 1; break; end
         end
         if (k == 0) begin bus.d_addr = 32'h14; bus.d_wdata = 32'h2222_2222; end
         else if (k == 1) begin bus.d_addr = 32'h0C; bus.d_wdata = 32'hAAAA_5555; end
         else begin bus.d_req = 1'b0; bus.d_lock = 1'b0; end
      end
      tests++; if (d_cnt - dd0 !== 3) begin fails++; $display("FAIL lock_d_ready got %0d want 3", d_cnt - dd0); end
      tests++; if (c_cnt - c0 !== 0) begin fails++; $display("FAIL lock_c_blocked got %0d want 0", c_cnt - c0); end
      tests++; if (wre_cnt - w0 !== 3) begin fails++; $display("FAIL lock_writes got %0d want 3", wre_cnt - w0); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         n++;
         if (bus.c_ready) break;
      end
      tests++; if (n < 1 || n > 3) begin fails++; $display("FAIL lock_release_latency got %0d want 1..3", n); end
      tests++; if (bus.c_rdata !== 32'hAAAA_5555) begin fails++; $display("FAIL lock_core_rdata got %h want aaaa5555", bus.c_rdata); end
      bus.c_req = 1'b0;
   endtask

   task automatic test_led();
      logic [31:0] rd;
      int          lat;
      logic        er;
      int          w0;
      w0 = wre_cnt;
      core_acc(1'b1, 32'h20, 32'h0000_002A, rd, lat, er);
      tests++; if (led !== 6'b010101) begin fails++; $display("FAIL led_write got %b want 010101", led); end
      tests++; if (wre_cnt - w0 !== 0) begin fails++; $display("FAIL led_no_ram got %0d want 0", wre_cnt - w0); end
      tests++; if (er !== 1'b0) begin fails++; $display("FAIL led_err got %b want 0", er); end
      core_acc(1'b0, 32'h20, 32'h0, rd, lat, er);
      tests++; if (rd !== 32'h0000_002A) begin fails++; $display("FAIL led_read got %h want 0000002a", rd); end
      core_acc(1'b0, 32'h23, 32'h0, rd, lat, er);
      tests++; if (rd !== 32'h0000_002A) begin fails++; $display("FAIL led_read_byte got %h want 0000002a", rd); end
   endtask

   task automatic test_unmapped();
      logic [31:0] rd;
      int          lat;
      logic        er;
      int          w0;
      core_acc(1'b1, 32'h00, 32'h0BAD_F00D, rd, lat, er);
      w0 = wre_cnt;
      core_acc(1'b0, 32'h100, 32'h0, rd, lat, er);
      tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL unm_rd_data got %h want deadbeef", rd); end
      tests++; if (er !== 1'b1) begin fails++; $display("FAIL unm_rd_err got %b want 1", er); end
      tests++; if (lat !== 3) begin fails++; $display("FAIL unm_rd_latency got %0d want 3", lat); end
      core_acc(1'b1, 32'h100, 32'hFFFF_FFFF, rd, lat, er);
      tests++; if (er !== 1'b1) begin fails++; $display("FAIL unm_wr_err got %b want 1", er); end
      tests++; if (wre_cnt - w0 !== 0) begin fails++; $display("FAIL unm_no_wre got %0d want 0", wre_cnt - w0); end
      core_acc(1'b0, 32'h00, 32'h0, rd, lat, er);
      tests++; if (rd !== 32'h0BAD_F00D) begin fails++; $display("FAIL unm_ram_kept got %h want 0badf00d", rd); end
      core_acc(1'b0, 32'h40, 32'h0, rd, lat, er);
      tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL unm_edge_data got %h want deadbeef", rd); end
      tests++; if (er !== 1'b1) begin fails++; $display("FAIL unm_edge_err got %b want 1", er); end
      core_acc(1'b0, 32'h3C, 32'h0, rd, lat, er);
      tests++; if (er !== 1'b0) begin fails++; $display("FAIL ram_edge_err got %b want 0", er); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int          lat;
      logic        er;
      int          dd0;
      dd0 = d_cnt;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_lock = 1'b0; bus.d_addr = 32'h20; bus.d_wdata = 32'h0000_003F;
      @(negedge clk); #1;
      sys_rst_n = 1'b0;
      #1;
      tests++; if (led !== 6'b111111) begin fails++; $display("FAIL mid_reset_led got %b want 111111", led); end
      tests++; if (bus.d_ready !== 1'b0) begin fails++; $display("FAIL mid_reset_d_ready got %b want 0", bus.d_ready); end
      bus.d_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      sys_rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      tests++; if (d_cnt - dd0 !== 0) begin fails++; $display("FAIL mid_reset_no_ready got %0d want 0", d_cnt - dd0); end
      tests++; if (led !== 6'b111111) begin fails++; $display("FAIL mid_reset_led_kept got %b want 111111", led); end
      dbg_acc(1'b0, 32'h04, 32'h0, rd, lat, er);
      tests++; if (lat !== 3) begin fails++; $display("FAIL mid_reset_next_latency got %0d want 3", lat); end
      tests++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL mid_reset_next_data got %h want 12345678", rd); end
   endtask

   initial begin
      sys_rst_n   = 1'b0;
      bus.c_req   = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
      bus.d_req   = 1'b0; bus.d_we = 1'b0; bus.d_lock = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      @(negedge clk); #1;
      test_reset();
      test_ram_rw();
      test_contention();
      test_lock();
      test_led();
      test_unmapped();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
